// File: rtl/xrog_interaction_scheduler_pkg.sv
// Shared types and constants for the cross-orbit interaction scheduler.
package xrog_pkg;

    typedef logic [7:0] orbit_t;

    localparam orbit_t CLOUD      = 8'd0;
    localparam orbit_t SOVEREIGN  = 8'd1;
    localparam orbit_t ENTERPRISE = 8'd2;
    localparam orbit_t OEM        = 8'd3;
    localparam orbit_t AI_AGENT   = 8'd4;
    localparam orbit_t CLUSTER    = 8'd5;

    typedef enum logic [1:0] {
        SCHED_IDLE    = 2'd0,
        SCHED_ISSUE   = 2'd1,
        SCHED_CAPTURE = 2'd2,
        SCHED_RESP    = 2'd3
    } sched_state_e;

    // Raw encodings, kept for tools and code that predate the enum.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef struct packed {
        logic [31:0] strength;
        logic [31:0] coupling;
        logic [7:0]  allowed;
    } ia_result_t;

    function automatic logic needs_swap(input orbit_t a, input orbit_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/xrog_interaction_scheduler_if.sv
// Requester and response channels between orbit clients and the scheduler.
// Valid/ready: a transfer happens on a clock edge where valid and ready are both
// high; the source holds valid and its payload stable until that edge.
interface xrog_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_orbit_a;
    logic [8*N_REQ-1:0] req_orbit_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_strength;
    logic [31:0]        rsp_coupling;
    logic [7:0]         rsp_allowed;
    logic               rsp_swapped;
    logic               rsp_denied;

    modport master (
        output req_valid, req_orbit_a, req_orbit_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_strength, rsp_coupling,
               rsp_allowed, rsp_swapped, rsp_denied
    );

    modport slave (
        input  req_valid, req_orbit_a, req_orbit_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_strength, rsp_coupling,
               rsp_allowed, rsp_swapped, rsp_denied
    );
endinterface

// File: rtl/xrog_interaction_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module xrog_rr_arbiter
    import xrog_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);
    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_w = ID_W'(idx);
            if (!any_o && req_i[idx_w]) begin
                any_o          = 1'b1;
                grant_o[idx_w] = 1'b1;
                id_o           = idx_w;
            end
        end
    end
endmodule

// File: rtl/xrog_interaction_scheduler.sv
// Round-robin front end for the shared interaction lookup unit: accept, issue,
// capture the one-cycle-latency result, then hold the response until taken.
module xrog_interaction_scheduler
    import xrog_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int STAT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    xrog_sched_if.slave        bus,
    output logic               ia_request,
    output orbit_t             ia_orbit_a,
    output orbit_t             ia_orbit_b,
    input  logic [31:0]        ia_strength,
    input  logic [31:0]        ia_coupling,
    input  logic [7:0]         ia_allowed,
    output logic               busy,
    input  logic               clr_stats,
    output logic [STAT_W-1:0]  stat_grant_cnt,
    output logic [STAT_W-1:0]  stat_deny_cnt,
    output sched_state_e       dbg_state
);
    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q, ptr_q, ptr_next;
    orbit_t            pair_a_q, pair_b_q;
    logic              swap_q;
    ia_result_t        res_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_swapped_q, rsp_denied_q;
    logic [STAT_W-1:0] grant_cnt_q, deny_cnt_q;

    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_id;
    logic              arb_any;
    orbit_t            sel_a, sel_b;
    logic              accept, handshake;

    xrog_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .id_o    (arb_id),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = bus.req_orbit_a[8*i +: 8];
                sel_b = bus.req_orbit_b[8*i +: 8];
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && arb_any;
    assign handshake = (state_q == ST_RESP) && bus.rsp_ready;
    assign ptr_next  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arb_any) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            id_q          <= '0;
            ptr_q         <= '0;
            pair_a_q      <= '0;
            pair_b_q      <= '0;
            swap_q        <= 1'b0;
            res_q         <= '0;
            rsp_id_q      <= '0;
            rsp_swapped_q <= 1'b0;
            rsp_denied_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= arb_id;
                // Canonical order keeps the lower orbit type on the A side.
                if (needs_swap(sel_a, sel_b)) begin
                    pair_a_q <= sel_b;
                    pair_b_q <= sel_a;
                    swap_q   <= 1'b1;
                end else begin
                    pair_a_q <= sel_a;
                    pair_b_q <= sel_b;
                    swap_q   <= 1'b0;
                end
            end
            if (state_q == ST_CAPTURE) begin
                res_q         <= '{strength: ia_strength, coupling: ia_coupling, allowed: ia_allowed};
                rsp_id_q      <= id_q;
                rsp_swapped_q <= swap_q;
                rsp_denied_q  <= (ia_allowed == 8'd0);
            end
            if (handshake) ptr_q <= ptr_next;
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            deny_cnt_q  <= '0;
        end else if (clr_stats) begin
            grant_cnt_q <= '0;
            deny_cnt_q  <= '0;
        end else if (handshake) begin
            if (grant_cnt_q != '1) grant_cnt_q <= grant_cnt_q + STAT_W'(1);
            if (rsp_denied_q && (deny_cnt_q != '1)) deny_cnt_q <= deny_cnt_q + STAT_W'(1);
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE) ? arb_grant : '0;
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_strength = res_q.strength;
    assign bus.rsp_coupling = res_q.coupling;
    assign bus.rsp_allowed  = res_q.allowed;
    assign bus.rsp_swapped  = rsp_swapped_q;
    assign bus.rsp_denied   = rsp_denied_q;

    assign ia_request     = (state_q == ST_ISSUE);
    assign ia_orbit_a     = pair_a_q;
    assign ia_orbit_b     = pair_b_q;
    assign busy           = (state_q != ST_IDLE);
    assign stat_grant_cnt = grant_cnt_q;
    assign stat_deny_cnt  = deny_cnt_q;
    assign dbg_state      = sched_state_e'(state_q);
endmodule
